// File: rtl/command_encoder.sv
// Encodes ALU requests into 12-bit command words, queues them in a small FIFO and
// presents them to the consumer through a valid/ready output register.
module command_encoder #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [2:0]                 op_in,
    input  logic [2:0]                 addr1_in,
    input  logic [2:0]                 addr2_in,
    input  logic [2:0]                 addr3_in,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [11:0]                command,
    output logic                       cmd_valid,
    input  logic                       cmd_ready,
    output logic [$clog2(DEPTH):0]     level,
    output logic [7:0]                 issued_cnt
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH) + 1;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    state_t      state, next_state;
    logic [11:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [11:0] enc_word;
    logic [11:0] head_word;
    logic        push, avail, load, pop_fifo, bypass, fifo_wr;

    function automatic logic [11:0] encode(input logic [2:0] op, input logic [2:0] a1,
                                           input logic [2:0] a2, input logic [2:0] a3);
        logic [11:0] w;
        w = 12'hE00;
        if (op <= 3'b011)
            w = {op, a1, a2, a3};
        else if (op == 3'b100)
            w = {op, a1, 3'b000, a3};
        return w;
    endfunction

    assign enc_word  = encode(op_in, addr1_in, addr2_in, addr3_in);
    assign in_ready  = (level != LW'(DEPTH));
    assign push      = in_valid && in_ready;
    assign avail     = (level != '0) || push;
    // An empty FIFO forwards the incoming word straight to the output register.
    assign head_word = (level != '0) ? mem[rd_ptr] : enc_word;
    assign pop_fifo  = load && (level != '0);
    assign bypass    = load && (level == '0);
    assign fifo_wr   = push && !bypass;
    assign cmd_valid = (state == PRESENT);

    always_comb begin
        next_state = state;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (avail) begin
                    load       = 1'b1;
                    next_state = PRESENT;
                end
            end
            PRESENT: begin
                if (cmd_ready) begin
                    if (avail)
                        load = 1'b1;
                    else
                        next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            command    <= 12'h000;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            issued_cnt <= 8'd0;
        end else begin
            state <= next_state;
            if (load)
                command <= head_word;
            if (fifo_wr)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop_fifo)
                rd_ptr <= rd_ptr + 1'b1;
            if (fifo_wr && !pop_fifo)
                level <= level + 1'b1;
            else if (pop_fifo && !fifo_wr)
                level <= level - 1'b1;
            if (cmd_valid && cmd_ready)
                issued_cnt <= issued_cnt + 8'd1;
        end
    end

    // Storage is never read while empty, so it needs no reset.
    always_ff @(posedge clk) begin
        if (fifo_wr)
            mem[wr_ptr] <= enc_word;
    end

endmodule

// File: tb/tb_command_encoder.sv
// Directed self-checking bench for command_encoder (DEPTH = 4).
module tb_command_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  op_in, addr1_in, addr2_in, addr3_in;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] command;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  level;
    logic [7:0]  issued_cnt;

    int total  = 0;
    int passed = 0;

    command_encoder #(.DEPTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .op_in      (op_in),
        .addr1_in   (addr1_in),
        .addr2_in   (addr2_in),
        .addr3_in   (addr3_in),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .command    (command),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .level      (level),
        .issued_cnt (issued_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached (observed running, required finished)");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic drive(input logic [2:0] op, input logic [2:0] a1, input logic [2:0] a2,
                         input logic [2:0] a3, input logic v);
        op_in    = op;
        addr1_in = a1;
        addr2_in = a2;
        addr3_in = a3;
        in_valid = v;
    endtask

    // Sequence words use ops 0..3 only, so the encoded word is the plain field concatenation.
    function automatic logic [11:0] word(input int k);
        return {3'(k % 4), 3'(k % 8), 3'((k + 1) % 8), 3'((k / 8) % 8)};
    endfunction

    task automatic drive_word(input int k);
        drive(3'(k % 4), 3'(k % 8), 3'((k + 1) % 8), 3'((k / 8) % 8), 1'b1);
    endtask

    logic [2:0]  t_op [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    logic [2:0]  t_a1 [8] = '{3'd1, 3'd3, 3'd7, 3'd4, 3'd2, 3'd1, 3'd7, 3'd5};
    logic [2:0]  t_a2 [8] = '{3'd2, 3'd5, 3'd0, 3'd4, 3'd7, 3'd2, 3'd7, 3'd5};
    logic [2:0]  t_a3 [8] = '{3'd3, 3'd6, 3'd1, 3'd4, 3'd5, 3'd3, 3'd7, 3'd5};
    logic [11:0] t_exp[8] = '{12'h053, 12'h2EE, 12'h5C1, 12'h724,
                              12'h885, 12'hE00, 12'hE00, 12'hE00};

    initial begin
        reset     = 1'b1;
        cmd_ready = 1'b0;
        drive(3'd0, 3'd0, 3'd0, 3'd0, 1'b0);
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        chk("rst_cmd_valid", cmd_valid, 0);
        chk("rst_command", command, 12'h000);
        chk("rst_level", level, 0);
        chk("rst_issued", issued_cnt, 0);
        chk("rst_in_ready", in_ready, 1);

        // Single SUB request
        cmd_ready = 1'b1;
        drive(3'b001, 3'd3, 3'd5, 3'd6, 1'b1);
        tick();
        in_valid = 1'b0;
        chk("single_command", command, 12'b001_011_101_110);
        chk("single_valid", cmd_valid, 1);
        chk("single_level", level, 0);
        tick();
        chk("single_valid_drop", cmd_valid, 0);
        chk("single_issued", issued_cnt, 1);

        // Encoding table streamed back to back
        for (int i = 0; i < 8; i++) begin
            drive(t_op[i], t_a1[i], t_a2[i], t_a3[i], 1'b1);
            tick();
            chk($sformatf("enc_cmd_%0d", i), command, t_exp[i]);
            chk($sformatf("enc_valid_%0d", i), cmd_valid, 1);
        end
        in_valid = 1'b0;
        tick();
        chk("enc_idle", cmd_valid, 0);
        chk("enc_issued", issued_cnt, 9);

        // Backpressure: DEPTH+2 pushes, one presented, DEPTH queued, last dropped
        cmd_ready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            drive(3'd0, 3'(i), 3'(i), 3'(i), 1'b1);
            tick();
            chk($sformatf("bp_level_%0d", i), level, (i - 1 < 4) ? i - 1 : 4);
            chk($sformatf("bp_cmd_%0d", i), command, 12'h049);
            chk($sformatf("bp_in_ready_%0d", i), in_ready, (i < 5) ? 1 : 0);
        end
        in_valid  = 1'b0;
        cmd_ready = 1'b1;
        for (int j = 2; j <= 5; j++) begin
            tick();
            chk($sformatf("bp_drain_cmd_%0d", j), command, {3'd0, 3'(j), 3'(j), 3'(j)});
            chk($sformatf("bp_drain_lvl_%0d", j), level, 5 - j);
        end
        tick();
        chk("bp_drain_idle", cmd_valid, 0);
        chk("bp_issued", issued_cnt, 14);

        // Reset while busy
        cmd_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_word(i);
            tick();
        end
        chk("rmid_level_pre", level, 3);
        chk("rmid_valid_pre", cmd_valid, 1);
        reset     = 1'b1;
        cmd_ready = 1'b1;
        drive_word(9);
        tick();
        reset    = 1'b0;
        in_valid = 1'b0;
        chk("rmid_level", level, 0);
        chk("rmid_valid", cmd_valid, 0);
        chk("rmid_command", command, 12'h000);
        chk("rmid_issued", issued_cnt, 0);
        chk("rmid_in_ready", in_ready, 1);

        // Streaming 20 cycles with continuous valid and ready
        for (int i = 0; i < 20; i++) begin
            drive_word(i);
            tick();
            chk($sformatf("stream_cmd_%0d", i), command, word(i));
            chk($sformatf("stream_lvl_%0d", i), (level <= 3'd1), 1);
        end
        chk("stream_issued", issued_cnt, 19);
        in_valid = 1'b0;
        tick();
        chk("stream_issued_end", issued_cnt, 20);
        chk("stream_idle", cmd_valid, 0);

        // Pointer wrap: keep two entries queued while streaming 3*DEPTH words
        cmd_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive_word(k);
            tick();
        end
        chk("wrap_prefill_lvl", level, 2);
        chk("wrap_prefill_cmd", command, word(0));
        cmd_ready = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            drive_word(n + 2);
            tick();
            chk($sformatf("wrap_cmd_%0d", n), command, word(n));
            chk($sformatf("wrap_lvl_%0d", n), level, 2);
        end
        in_valid = 1'b0;
        tick();
        chk("wrap_tail_cmd13", command, word(13));
        tick();
        chk("wrap_tail_cmd14", command, word(14));
        chk("wrap_tail_lvl", level, 0);
        tick();
        chk("wrap_tail_idle", cmd_valid, 0);
        chk("wrap_issued", issued_cnt, 35);

        // issued_cnt wrap after 256 handshakes
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 256; i++) begin
            drive_word(i);
            tick();
        end
        chk("cnt_255", issued_cnt, 255);
        in_valid = 1'b0;
        tick();
        chk("cnt_wrap", issued_cnt, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/command_encoder.md
COMMAND_ENCODER -- requirements
Module: command_encoder

Interface
REQ-001 Parameter: DEPTH, default 4, number of entries in the encoded-command FIFO (power of two, 2..16).
REQ-002 clk  input  1  single system clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 op_in  input  3  requested operation: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 NOT; 101..111 treated as NOP.
REQ-005 addr1_in, addr2_in, addr3_in  input  3 each  register-file addresses for operand 1, operand 2 and destination.
REQ-006 in_valid  input  1  producer presents a request.
REQ-007 in_ready  output  1  encoder can accept a request this cycle; equals NOT full.
REQ-008 command  output  12  encoded word {op[11:9], addr1[8:6], addr2[5:3], addr3[2:0]}.
REQ-009 cmd_valid  output  1  command holds a valid word.
REQ-010 cmd_ready  input  1  consumer accepts command this cycle.
REQ-011 level  output  $clog2(DEPTH)+1  number of FIFO entries.
REQ-012 issued_cnt  output  8  count of commands accepted by the consumer.

Function
REQ-013 The block SHALL accept a request when in_valid && in_ready and SHALL write its encoded word into the FIFO on that edge.
REQ-014 Encoding SHALL be: ADD/SUB/AND/OR keep all fields; NOT forces addr2 to 000; any op 101..111 yields 12'b111_000_000_000.
REQ-015 The FIFO SHALL be first-in first-out, with read/write pointers that wrap from DEPTH-1 to 0.
REQ-016 The output stage SHALL be a two-state FSM: IDLE (cmd_valid=0) and PRESENT (cmd_valid=1).
REQ-017 IDLE -> PRESENT SHALL occur on the edge after the FIFO becomes non-empty, loading the head entry into command and popping it; minimum latency from an accepted request to cmd_valid is 1 cycle when empty.
REQ-018 In PRESENT, command and cmd_valid SHALL remain stable until cmd_ready=1.
REQ-019 On a handshake (cmd_valid && cmd_ready), if the FIFO is non-empty the next head SHALL be loaded the same edge (back-to-back, one command per cycle); otherwise the FSM SHALL return to IDLE.
REQ-020 issued_cnt SHALL increment by 1 on each handshake and SHALL wrap from 255 to 0.
REQ-021 Full: when level==DEPTH, in_ready SHALL be 0 and in_valid SHALL be ignored without corrupting contents.
REQ-022 Empty: when level==0 and the FSM is IDLE, no pop SHALL occur and cmd_valid SHALL stay 0.
REQ-023 A push and a pop on the same edge SHALL leave level unchanged, including when full (in_ready stays 0 that cycle, so no push) and when empty (word passes through the FIFO and is presented next cycle).
REQ-024 level SHALL count FIFO entries only; the word held in command is not counted.

Reset
REQ-025 When reset=1 at a clock edge: FIFO pointers and level=0, FSM=IDLE, cmd_valid=0, command=12'h000, issued_cnt=0; in_ready=1 on the following cycle.
REQ-026 Reset SHALL take priority over any simultaneous push, pop or handshake; words in flight SHALL be discarded.
REQ-027 No output SHALL be undefined after the first reset edge.

Verification
REQ-028 Single op: op_in=001, addr=3/5/6, in_valid pulse, cmd_ready=1 -> next cycle command=12'b001_011_101_110, cmd_valid=1 for 1 cycle, issued_cnt=1.
REQ-029 Encoding: NOT with addr2=7 -> addr2 field 000; op 110 with any addresses -> 12'hE00.
REQ-030 Backpressure/full: cmd_ready=0, push DEPTH+2 requests -> the first is presented and DEPTH entries queue (level=DEPTH), in_ready=0, extra requests dropped; command stable; then cmd_ready=1 -> DEPTH+1 words in order on consecutive cycles.
REQ-031 Streaming: in_valid=1 and cmd_ready=1 continuously for 20 cycles -> one command per cycle after 1-cycle latency, level stays <=1, issued_cnt=19 after 20 cycles.
REQ-032 Reset mid-operation: level=3, cmd_valid=1, assert reset with in_valid=1 -> next cycle level=0, cmd_valid=0, command=000, issued_cnt=0.
REQ-033 Wrap: 256 handshakes -> issued_cnt returns to 0; pointer wrap verified by in-order data across 3*DEPTH pushes.
